// File: rtl/mips_mem_pkg.sv
// Shared types, constants and address helpers for the MIPS data-memory responder.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        HOST_IDLE = 2'd0,
        HOST_WAIT = 2'd1,
        HOST_ACK  = 2'd2
    } hostState_e;

    localparam logic [31:0] FAULT_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // Word index of a byte address, masked to the storage depth.
    function automatic logic [31:0] word_index(input logic [31:0] addr, input int unsigned addrW);
        return (addr >> 2) & ((32'd1 << addrW) - 32'd1);
    endfunction

    // A core address is legal when word aligned and inside the storage window.
    function automatic logic addr_legal(input logic [31:0] addr, input int unsigned addrW);
        return (addr[1:0] == 2'b00) && ((addr >> (addrW + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/mips_mem_array.sv
// Word storage: one synchronous write port and two combinational read ports.
// Contents are deliberately not reset so a loaded image survives a reset.
module mips_mem_array #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clock_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddrA_i,
    output logic [31:0]       rdataA_o,
    input  logic [ADDR_W-1:0] raddrB_i,
    output logic [31:0]       rdataB_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [31:0] mem [DEPTH];

    // Single write port, shared between core and host by the parent.
    always_ff @(posedge clock_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdataA_o = mem[raddrA_i];
    assign rdataB_o = mem[raddrB_i];

endmodule

// File: rtl/mips_data_mem_responder.sv
// Memory-side responder for the core's data port, with a host/loader port
// that only gets the storage in cycles the core leaves idle, and a sticky
// fault record for misaligned, out-of-range or read+write core accesses.
module mips_data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter logic [31:0] FAULT_RDATA = FAULT_RDATA_DEFAULT
) (
    input  logic              clock__i,
    input  logic              reset__i,
    input  logic [31:0]       memAddr__i,
    input  logic [31:0]       memDataWrite__i,
    input  logic              memRead__i,
    input  logic              memWrite__i,
    output logic [31:0]       memDataRead__o,
    input  logic              hostReq__i,
    input  logic              hostWe__i,
    input  logic [ADDR_W-1:0] hostAddr__i,
    input  logic [31:0]       hostWData__i,
    input  logic              hostClrFault__i,
    output logic              hostAck__o,
    output logic [31:0]       hostRData__o,
    output logic              fault__o,
    output logic [31:0]       faultAddr__o,
    output logic              faultWrite__o
);

    hostState_e        state_q, state_d;
    logic [31:0]       hostRData_q, hostRData_d;
    logic              fault_q, fault_d;
    logic [31:0]       faultAddr_q, faultAddr_d;
    logic              faultWrite_q, faultWrite_d;

    logic              coreAccess;
    logic              coreLegal;
    logic              coreFault;
    logic              coreWriteEn;
    logic [ADDR_W-1:0] coreIdx;
    logic [31:0]       coreRdPort;
    logic [31:0]       hostRdPort;
    logic              hostDoAccess;
    logic              arrWe;
    logic [ADDR_W-1:0] arrAddr;
    logic [31:0]       arrData;

    assign coreAccess  = memRead__i | memWrite__i;
    assign coreLegal   = addr_legal(memAddr__i, ADDR_W) && !(memRead__i && memWrite__i);
    assign coreFault   = coreAccess && !coreLegal;
    assign coreWriteEn = memWrite__i && coreLegal;
    assign coreIdx     = ADDR_W'(word_index(memAddr__i, ADDR_W));

    mips_mem_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clock_i (clock__i),
        .we_i    (arrWe),
        .waddr_i (arrAddr),
        .wdata_i (arrData),
        .raddrA_i(coreIdx),
        .rdataA_o(coreRdPort),
        .raddrB_i(hostAddr__i),
        .rdataB_o(hostRdPort)
    );

    // Core load data: zero when not reading, fault pattern on an illegal read.
    always_comb begin
        memDataRead__o = 32'd0;
        if (memRead__i) begin
            memDataRead__o = coreLegal ? coreRdPort : FAULT_RDATA;
        end
    end

    // Host FSM state register.
    always_ff @(posedge clock__i or posedge reset__i) begin
        if (reset__i) begin
            state_q <= HOST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Host FSM next state: WAIT only advances in a cycle with no core strobe.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HOST_IDLE: if (hostReq__i) state_d = HOST_WAIT;
            HOST_WAIT: if (!coreAccess) state_d = HOST_ACK;
            HOST_ACK:  if (!hostReq__i) state_d = HOST_IDLE;
            default:   state_d = HOST_IDLE;
        endcase
    end

    // Host FSM outputs: the grant cycle drives the array port and read capture.
    always_comb begin
        hostDoAccess = (state_q == HOST_WAIT) && !coreAccess;
        hostRData_d  = hostRData_q;
        if (hostDoAccess && !hostWe__i) begin
            hostRData_d = hostRdPort;
        end
        arrWe   = coreWriteEn || (hostDoAccess && hostWe__i);
        arrAddr = coreWriteEn ? coreIdx : hostAddr__i;
        arrData = coreWriteEn ? memDataWrite__i : hostWData__i;
    end

    // Host read data holds its value across writes and the ACK phase.
    always_ff @(posedge clock__i or posedge reset__i) begin
        if (reset__i) begin
            hostRData_q <= 32'd0;
        end else begin
            hostRData_q <= hostRData_d;
        end
    end

    // Fault record next state: capture first fault, a same-cycle clear loses to a new fault.
    always_comb begin
        fault_d      = fault_q;
        faultAddr_d  = faultAddr_q;
        faultWrite_d = faultWrite_q;
        if (coreFault && (!fault_q || hostClrFault__i)) begin
            fault_d      = 1'b1;
            faultAddr_d  = memAddr__i;
            faultWrite_d = memWrite__i;
        end else if (hostClrFault__i) begin
            fault_d      = 1'b0;
            faultAddr_d  = 32'd0;
            faultWrite_d = 1'b0;
        end
    end

    // Fault record registers.
    always_ff @(posedge clock__i or posedge reset__i) begin
        if (reset__i) begin
            fault_q      <= 1'b0;
            faultAddr_q  <= 32'd0;
            faultWrite_q <= 1'b0;
        end else begin
            fault_q      <= fault_d;
            faultAddr_q  <= faultAddr_d;
            faultWrite_q <= faultWrite_d;
        end
    end

    assign hostAck__o    = (state_q == HOST_ACK);
    assign hostRData__o  = hostRData_q;
    assign fault__o      = fault_q;
    assign faultAddr__o  = faultAddr_q;
    assign faultWrite__o = faultWrite_q;

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Directed bench for mips_data_mem_responder with ADDR_W=10.
module tb_mips_data_mem_responder;

    logic        clock__i = 1'b0;
    logic        reset__i;
    logic [31:0] memAddr__i;
    logic [31:0] memDataWrite__i;
    logic        memRead__i;
    logic        memWrite__i;
    logic [31:0] memDataRead__o;
    logic        hostReq__i;
    logic        hostWe__i;
    logic [9:0]  hostAddr__i;
    logic [31:0] hostWData__i;
    logic        hostClrFault__i;
    logic        hostAck__o;
    logic [31:0] hostRData__o;
    logic        fault__o;
    logic [31:0] faultAddr__o;
    logic        faultWrite__o;

    int passCount  = 0;
    int totalCount = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        logic [31:0] expRead;
    } coreVec_t;

    coreVec_t vecs[8];

    mips_data_mem_responder #(
        .ADDR_W(10)
    ) dut (
        .clock__i       (clock__i),
        .reset__i       (reset__i),
        .memAddr__i     (memAddr__i),
        .memDataWrite__i(memDataWrite__i),
        .memRead__i     (memRead__i),
        .memWrite__i    (memWrite__i),
        .memDataRead__o (memDataRead__o),
        .hostReq__i     (hostReq__i),
        .hostWe__i      (hostWe__i),
        .hostAddr__i    (hostAddr__i),
        .hostWData__i   (hostWData__i),
        .hostClrFault__i(hostClrFault__i),
        .hostAck__o     (hostAck__o),
        .hostRData__o   (hostRData__o),
        .fault__o       (fault__o),
        .faultAddr__o   (faultAddr__o),
        .faultWrite__o  (faultWrite__o)
    );

    // Free-running 10 ns clock.
    always #5 clock__i = ~clock__i;

    // Compare one value and keep the pass/total tallies.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Advance past the next rising edge so registered outputs have settled.
    task automatic applyStimulus();
        @(posedge clock__i);
        #2;
    endtask

    // Drive all core strobes inactive.
    task automatic coreIdle();
        memRead__i  = 1'b0;
        memWrite__i = 1'b0;
        memAddr__i  = 32'd0;
    endtask

    // Main directed sequence: reset, table of legal core accesses, then multi-cycle corners.
    initial begin
        reset__i        = 1'b1;
        memAddr__i      = 32'd0;
        memDataWrite__i = 32'd0;
        memRead__i      = 1'b0;
        memWrite__i     = 1'b0;
        hostReq__i      = 1'b0;
        hostWe__i       = 1'b0;
        hostAddr__i     = 10'd0;
        hostWData__i    = 32'd0;
        hostClrFault__i = 1'b0;

        vecs[0] = '{addr: 32'h0000_0010, wdata: 32'h1234_5678, rd: 1'b0, wr: 1'b1, expRead: 32'h0};
        vecs[1] = '{addr: 32'h0000_0010, wdata: 32'h0,         rd: 1'b1, wr: 1'b0, expRead: 32'h1234_5678};
        vecs[2] = '{addr: 32'h0000_0FFC, wdata: 32'hA5A5_0001, rd: 1'b0, wr: 1'b1, expRead: 32'h0};
        vecs[3] = '{addr: 32'h0000_0FFC, wdata: 32'h0,         rd: 1'b1, wr: 1'b0, expRead: 32'hA5A5_0001};
        vecs[4] = '{addr: 32'h0000_0000, wdata: 32'h0BAD_F00D, rd: 1'b0, wr: 1'b1, expRead: 32'h0};
        vecs[5] = '{addr: 32'h0000_0000, wdata: 32'h0,         rd: 1'b1, wr: 1'b0, expRead: 32'h0BAD_F00D};
        vecs[6] = '{addr: 32'h0000_0010, wdata: 32'h0,         rd: 1'b0, wr: 1'b0, expRead: 32'h0};
        vecs[7] = '{addr: 32'h0000_0010, wdata: 32'h0,         rd: 1'b1, wr: 1'b0, expRead: 32'h1234_5678};

        #3;
        checkOutput("rst_ack", hostAck__o, 32'd0);
        checkOutput("rst_rdata", hostRData__o, 32'd0);
        checkOutput("rst_fault", fault__o, 32'd0);
        checkOutput("rst_faultAddr", faultAddr__o, 32'd0);
        checkOutput("rst_faultWrite", faultWrite__o, 32'd0);
        applyStimulus();
        reset__i = 1'b0;

        for (int i = 0; i < 8; i++) begin
            memAddr__i      = vecs[i].addr;
            memDataWrite__i = vecs[i].wdata;
            memRead__i      = vecs[i].rd;
            memWrite__i     = vecs[i].wr;
            #1;
            checkOutput($sformatf("vec%0d_read", i), memDataRead__o, vecs[i].expRead);
            applyStimulus();
            checkOutput($sformatf("vec%0d_fault", i), fault__o, 32'd0);
        end
        coreIdle();

        memRead__i = 1'b1;
        memAddr__i = 32'h0000_0006;
        #1;
        checkOutput("misalign_rdata", memDataRead__o, 32'hDEAD_BEEF);
        applyStimulus();
        checkOutput("misalign_fault", fault__o, 32'd1);
        checkOutput("misalign_faultAddr", faultAddr__o, 32'h6);
        checkOutput("misalign_faultWrite", faultWrite__o, 32'd0);
        memAddr__i = 32'h0000_1000;
        #1;
        checkOutput("range_rdata", memDataRead__o, 32'hDEAD_BEEF);
        applyStimulus();
        checkOutput("sticky_faultAddr", faultAddr__o, 32'h6);
        checkOutput("sticky_fault", fault__o, 32'd1);
        coreIdle();

        hostReq__i   = 1'b1;
        hostWe__i    = 1'b1;
        hostAddr__i  = 10'd5;
        hostWData__i = 32'hCAFE_F00D;
        memRead__i   = 1'b1;
        memAddr__i   = 32'h0000_0010;
        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            checkOutput($sformatf("busy%0d_ack", c), hostAck__o, 32'd0);
        end
        coreIdle();
        applyStimulus();
        checkOutput("hostwr_ack", hostAck__o, 32'd1);
        memRead__i = 1'b1;
        memAddr__i = 32'h0000_0014;
        #1;
        checkOutput("hostwr_coreRead", memDataRead__o, 32'hCAFE_F00D);
        coreIdle();
        hostReq__i = 1'b0;
        applyStimulus();
        checkOutput("hostwr_ackDrop", hostAck__o, 32'd0);

        hostReq__i = 1'b1;
        hostWe__i  = 1'b0;
        hostAddr__i = 10'd5;
        applyStimulus();
        checkOutput("hostrd_ack1", hostAck__o, 32'd0);
        applyStimulus();
        checkOutput("hostrd_ack2", hostAck__o, 32'd1);
        checkOutput("hostrd_rdata", hostRData__o, 32'hCAFE_F00D);
        applyStimulus();
        checkOutput("hostrd_ackHold", hostAck__o, 32'd1);
        hostReq__i = 1'b0;
        applyStimulus();
        checkOutput("hostrd_ackDrop", hostAck__o, 32'd0);

        hostClrFault__i = 1'b1;
        applyStimulus();
        hostClrFault__i = 1'b0;
        checkOutput("clr_fault", fault__o, 32'd0);
        checkOutput("clr_faultAddr", faultAddr__o, 32'd0);
        memWrite__i     = 1'b1;
        memAddr__i      = 32'h0000_1000;
        memDataWrite__i = 32'hFFFF_FFFF;
        applyStimulus();
        coreIdle();
        checkOutput("oorwr_fault", fault__o, 32'd1);
        checkOutput("oorwr_faultWrite", faultWrite__o, 32'd1);
        checkOutput("oorwr_faultAddr", faultAddr__o, 32'h0000_1000);
        hostReq__i  = 1'b1;
        hostWe__i   = 1'b0;
        hostAddr__i = 10'd0;
        applyStimulus();
        applyStimulus();
        checkOutput("oorwr_hostAck", hostAck__o, 32'd1);
        checkOutput("oorwr_storage", hostRData__o, 32'h0BAD_F00D);
        hostReq__i = 1'b0;
        applyStimulus();
        hostClrFault__i = 1'b1;
        memWrite__i     = 1'b1;
        memAddr__i      = 32'h0000_0022;
        applyStimulus();
        hostClrFault__i = 1'b0;
        coreIdle();
        checkOutput("clrset_fault", fault__o, 32'd1);
        checkOutput("clrset_faultAddr", faultAddr__o, 32'h0000_0022);
        checkOutput("clrset_faultWrite", faultWrite__o, 32'd1);

        hostReq__i  = 1'b1;
        hostWe__i   = 1'b0;
        hostAddr__i = 10'h3FF;
        memRead__i  = 1'b1;
        memAddr__i  = 32'h0000_0010;
        applyStimulus();
        applyStimulus();
        reset__i = 1'b1;
        #1;
        checkOutput("arst_ack", hostAck__o, 32'd0);
        checkOutput("arst_fault", fault__o, 32'd0);
        checkOutput("arst_faultAddr", faultAddr__o, 32'd0);
        checkOutput("arst_rdata", hostRData__o, 32'd0);
        coreIdle();
        #2;
        reset__i = 1'b0;
        applyStimulus();
        checkOutput("rearb_ack1", hostAck__o, 32'd0);
        applyStimulus();
        checkOutput("rearb_ack2", hostAck__o, 32'd1);
        checkOutput("rearb_rdata", hostRData__o, 32'hA5A5_0001);
        memRead__i = 1'b1;
        memAddr__i = 32'h0000_0FFC;
        #1;
        checkOutput("retain_coreRead", memDataRead__o, 32'hA5A5_0001);
        coreIdle();
        hostReq__i = 1'b0;
        applyStimulus();
        checkOutput("rearb_ackDrop", hostAck__o, 32'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
